// File: rtl/scc_dump_pkg.sv
// Shared types for the SCC halt-triggered memory dump engine.
package scc_dump_pkg;

   localparam int REC_ADDR_W = 32;
   localparam int REC_DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_RD,
      S_CAP,
      S_EMIT,
      S_DONE,
      S_TRAILER
   } state_t;

   typedef struct packed {
      logic                  hdr;
      logic [REC_ADDR_W-1:0] addr;
      logic [REC_DATA_W-1:0] value;
   } rec_t;

endpackage

// File: rtl/scc_mem_dump.sv
// Halt-triggered data-memory dump engine. After halt_f it walks DUMP_WORDS
// words from DUMP_BASE and streams one header plus one (addr, value) record
// per word on a valid/ready interface.
// Build option SCC_DUMP_SKIP_ZERO_EN: zero-valued words are not emitted and
// the header (carrying the non-zero count) is sent last as a trailer.
//
// state   | meaning
// IDLE    | waiting for halt (latched or live)
// HDR     | header record offered (header-first build)
// RD      | read strobe to data memory
// CAP     | read data returns, captured into hold register
// EMIT    | word record offered
// TRAILER | header record offered after last word (skip-zero build)
// DONE    | dump complete, held until rst
module scc_mem_dump
   import scc_dump_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
   parameter int                DUMP_WORDS = 2048,
   parameter int                ADDR_STEP  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              halt_f,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic              rec_hdr,
   output logic [ADDR_W-1:0] rec_addr,
   output logic [DATA_W-1:0] rec_value,
   output logic              busy,
   output logic              dump_done
);

   localparam int               CNT_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DUMP_WORDS - 1);

   state_t            state, state_nx;
   logic              halt_lat;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] hold;
   logic              adv;
   logic              last;
   rec_t              rec;
`ifdef SCC_DUMP_SKIP_ZERO_EN
   logic [DATA_W-1:0] nz_cnt;
`endif

   assign last = (cnt == LAST);

   // State register, halt latch and word datapath; everything frozen when clk_en=0
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         halt_lat <= 1'b0;
         cnt      <= '0;
         addr     <= DUMP_BASE;
         hold     <= '0;
`ifdef SCC_DUMP_SKIP_ZERO_EN
         nz_cnt   <= '0;
`endif
      end else if (clk_en) begin
         state <= state_nx;
         if (halt_f)
            halt_lat <= 1'b1;
         if (state == S_CAP)
            hold <= mem_rd_data;
         if (adv) begin
            cnt  <= cnt + CNT_W'(1);
            addr <= addr + ADDR_W'(ADDR_STEP);
         end
`ifdef SCC_DUMP_SKIP_ZERO_EN
         if (state == S_CAP && mem_rd_data != '0)
            nz_cnt <= nz_cnt + DATA_W'(1);
`endif
      end
   end

   // Next-state and output decode; payload is a pure function of state and
   // registers, so it stays stable while a record waits for rec_ready
   always_comb begin
      state_nx    = state;
      rec         = '0;
      rec_valid   = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      busy        = 1'b0;
      dump_done   = 1'b0;
      adv         = 1'b0;
      case (state)
         S_IDLE: begin
`ifdef SCC_DUMP_SKIP_ZERO_EN
            if (halt_lat || halt_f) state_nx = S_RD;
`else
            if (halt_lat || halt_f) state_nx = S_HDR;
`endif
         end
         S_HDR: begin
            busy      = 1'b1;
            rec_valid = 1'b1;
            rec.hdr   = 1'b1;
            rec.addr  = REC_ADDR_W'(DUMP_WORDS);
            if (rec_ready) state_nx = S_RD;
         end
         S_RD: begin
            busy        = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = addr;
            state_nx    = S_CAP;
         end
         S_CAP: begin
            busy     = 1'b1;
            state_nx = S_EMIT;
`ifdef SCC_DUMP_SKIP_ZERO_EN
            if (mem_rd_data == '0) begin
               adv      = !last;
               state_nx = last ? S_TRAILER : S_RD;
            end
`endif
         end
         S_EMIT: begin
            busy      = 1'b1;
            rec_valid = 1'b1;
            rec.addr  = REC_ADDR_W'(addr);
            rec.value = REC_DATA_W'(hold);
            if (rec_ready) begin
               if (last) begin
`ifdef SCC_DUMP_SKIP_ZERO_EN
                  state_nx = S_TRAILER;
`else
                  state_nx = S_DONE;
`endif
               end else begin
                  adv      = 1'b1;
                  state_nx = S_RD;
               end
            end
         end
`ifdef SCC_DUMP_SKIP_ZERO_EN
         S_TRAILER: begin
            busy      = 1'b1;
            rec_valid = 1'b1;
            rec.hdr   = 1'b1;
            rec.addr  = REC_ADDR_W'(DUMP_WORDS);
            rec.value = REC_DATA_W'(nz_cnt);
            if (rec_ready) state_nx = S_DONE;
         end
`endif
         S_DONE: begin
            dump_done = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign rec_hdr   = rec.hdr;
   assign rec_addr  = ADDR_W'(rec.addr);
   assign rec_value = DATA_W'(rec.value);

endmodule

// File: tb/tb_scc_mem_dump.sv
// Self-checking bench for scc_mem_dump (DUMP_BASE=0x4FE, DUMP_WORDS=4).
// Honours SCC_DUMP_SKIP_ZERO_EN when building expectations.
module tb_scc_mem_dump;

   localparam logic [31:0] BASE  = 32'h0000_04FE;
   localparam int          WORDS = 4;

   typedef struct packed {
      logic        hdr;
      logic [31:0] addr;
      logic [31:0] value;
   } trec_t;

   typedef struct {
      bit       rst, en, halt, rdy;
      bit [3:0] exp;   // {busy, rec_valid, mem_rd_en, dump_done}
   } vec_t;

   typedef struct {
      int pct;
      bit tog;
      bit rnd_mem;
   } scen_t;

`ifdef SCC_DUMP_SKIP_ZERO_EN
   localparam bit [3:0] FIRST_EXP = 4'b1010;
`else
   localparam bit [3:0] FIRST_EXP = 4'b1100;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        halt_f = 1'b0;
   logic        mem_rd_en;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic        rec_valid;
   logic        rec_ready = 1'b0;
   logic        rec_hdr;
   logic [31:0] rec_addr;
   logic [31:0] rec_value;
   logic        busy;
   logic        dump_done;

   int    n_chk = 0;
   int    n_pass = 0;
   bit    drv_on = 0;
   bit    mon_on = 0;
   int    ready_pct = 100;
   bit    toggle = 0;
   int    stab_err = 0;
   logic [31:0] mem_vals [4];
   trec_t obs [$];
   trec_t exp_q [$];
   bit    pend = 0;
   trec_t pend_rec;

   scc_mem_dump #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .DUMP_BASE (BASE),
      .DUMP_WORDS(WORDS),
      .ADDR_STEP (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .halt_f     (halt_f),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .rec_valid  (rec_valid),
      .rec_ready  (rec_ready),
      .rec_hdr    (rec_hdr),
      .rec_addr   (rec_addr),
      .rec_value  (rec_value),
      .busy       (busy),
      .dump_done  (dump_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_lookup(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off < 32'd4) return mem_vals[off[1:0]];
      return a;
   endfunction

   // Data memory: one-cycle read latency
   always @(posedge clk)
      if (mem_rd_en) mem_rd_data <= mem_lookup(mem_rd_addr);

   // Randomised clk_en / rec_ready driver
   always @(posedge clk) begin
      #1;
      if (drv_on) begin
         clk_en    = toggle ? ~clk_en : 1'b1;
         rec_ready = ($urandom_range(1, 100) <= ready_pct);
      end
   end

   // Stream monitor: collects accepted records and checks hold-while-stalled
   always @(negedge clk) begin
      if (mon_on) begin
         if (rst) begin
            pend = 0;
         end else begin
            if (pend && !(rec_valid && {rec_hdr, rec_addr, rec_value} == pend_rec))
               stab_err++;
            if (rec_valid && clk_en && rec_ready) begin
               obs.push_back({rec_hdr, rec_addr, rec_value});
               pend = 0;
            end else if (rec_valid) begin
               pend     = 1;
               pend_rec = {rec_hdr, rec_addr, rec_value};
            end else begin
               pend = 0;
            end
         end
      end
   end

   task automatic chk(input bit ok, input string name, input string got_s, input string exp_s);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %s expected %s", name, got_s, exp_s);
   endtask

   // Reference model: record list straight from the dump rules
   task automatic build_expected();
      int nz;
      exp_q.delete();
      nz = 0;
`ifdef SCC_DUMP_SKIP_ZERO_EN
      for (int i = 0; i < WORDS; i++)
         if (mem_vals[i] != 0) begin
            exp_q.push_back({1'b0, BASE + 32'(i), mem_vals[i]});
            nz++;
         end
      exp_q.push_back({1'b1, 32'(WORDS), 32'(nz)});
`else
      exp_q.push_back({1'b1, 32'(WORDS), 32'd0});
      for (int i = 0; i < WORDS; i++)
         exp_q.push_back({1'b0, BASE + 32'(i), mem_vals[i]});
`endif
   endtask

   task automatic set_fixed_mem();
`ifdef SCC_DUMP_SKIP_ZERO_EN
      mem_vals[0] = 32'd0;  mem_vals[1] = 32'd5;
      mem_vals[2] = 32'd0;  mem_vals[3] = 32'h37;
`else
      mem_vals[0] = 32'h4FE; mem_vals[1] = 32'h4FF;
      mem_vals[2] = 32'h37;  mem_vals[3] = 32'h501;
`endif
   endtask

   task automatic do_reset();
      drv_on = 0;
      @(posedge clk); #2;
      clk_en = 1'b1; rst = 1'b1; halt_f = 1'b0; rec_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // Raise halt_f until one clk_en cycle has sampled it
   task automatic pulse_halt();
      @(posedge clk); #2;
      halt_f = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (clk_en) break;
      end
      @(posedge clk); #2;
      halt_f = 1'b0;
   endtask

   task automatic run_dump(input int pct, input bit tog, output int cyc);
      obs.delete();
      stab_err  = 0;
      ready_pct = pct;
      toggle    = tog;
      drv_on    = 1;
      mon_on    = 1;
      pulse_halt();
      cyc = 0;
      while (!dump_done && cyc < 5000) begin
         @(posedge clk);
         cyc++;
      end
      #2;
   endtask

   task automatic compare_dump(input string tag);
      build_expected();
      chk(dump_done === 1'b1, {tag, "_done"}, $sformatf("%b", dump_done), "1");
      chk(busy === 1'b0 && rec_valid === 1'b0, {tag, "_idle_after"},
          $sformatf("busy=%b valid=%b", busy, rec_valid), "busy=0 valid=0");
      chk(obs.size() == exp_q.size(), {tag, "_count"},
          $sformatf("%0d", obs.size()), $sformatf("%0d", exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs.size())
            chk(obs[i] == exp_q[i], $sformatf("%s_rec%0d", tag, i),
                $sformatf("hdr=%b addr=%h val=%h", obs[i].hdr, obs[i].addr, obs[i].value),
                $sformatf("hdr=%b addr=%h val=%h", exp_q[i].hdr, exp_q[i].addr, exp_q[i].value));
      end
      chk(stab_err == 0, {tag, "_stable"}, $sformatf("%0d violations", stab_err), "0");
   endtask

   initial begin
      vec_t  vecs [8];
      scen_t scens [6];
      int    cyc, cyc_base, cyc_tog, n_before, guard;
      bit    idle_ok;

      vecs[0] = '{0, 1, 0, 0, 4'b0000};
      vecs[1] = '{0, 1, 0, 1, 4'b0000};
      vecs[2] = '{0, 0, 1, 1, 4'b0000};   // halt while gated: not latched
      vecs[3] = '{0, 1, 0, 1, 4'b0000};
      vecs[4] = '{0, 1, 1, 0, FIRST_EXP};
      vecs[5] = '{0, 0, 0, 1, FIRST_EXP}; // gated: no handshake, state held
      vecs[6] = '{1, 1, 0, 1, 4'b0000};
      vecs[7] = '{0, 1, 0, 1, 4'b0000};   // latch cleared by rst

      scens[0] = '{100, 0, 0};
      scens[1] = '{100, 1, 0};
      scens[2] = '{30, 0, 0};
      scens[3] = '{30, 0, 1};
      scens[4] = '{30, 1, 1};
      scens[5] = '{60, 0, 1};

      set_fixed_mem();
      do_reset();

      // Reset then idle for 100 cycles
      idle_ok = 1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (rec_valid !== 0 || mem_rd_en !== 0 || busy !== 0 || dump_done !== 0) idle_ok = 0;
      end
      chk(idle_ok, "idle_100", $sformatf("%b", idle_ok), "1");

      // Cycle-level vectors
      @(posedge clk); #2;
      for (int i = 0; i < 8; i++) begin
         rst = vecs[i].rst; clk_en = vecs[i].en; halt_f = vecs[i].halt; rec_ready = vecs[i].rdy;
         @(posedge clk); #1;
         chk({busy, rec_valid, mem_rd_en, dump_done} === vecs[i].exp, $sformatf("vec%0d", i),
             $sformatf("%b", {busy, rec_valid, mem_rd_en, dump_done}), $sformatf("%b", vecs[i].exp));
      end
`ifndef SCC_DUMP_SKIP_ZERO_EN
      rst = 1'b0; clk_en = 1'b1; halt_f = 1'b1; rec_ready = 1'b0;
      @(posedge clk); #1;
      halt_f = 1'b0;
      chk(rec_hdr === 1'b1 && rec_addr === 32'(WORDS) && rec_value === 32'd0, "hdr_payload",
          $sformatf("hdr=%b addr=%h val=%h", rec_hdr, rec_addr, rec_value),
          $sformatf("hdr=1 addr=%h val=0", WORDS));
`endif
      rst = 1'b0; halt_f = 1'b0; clk_en = 1'b1;

      // Full dumps under the scenario table
      cyc_base = 0; cyc_tog = 0;
      for (int s = 0; s < 6; s++) begin
         do_reset();
         if (scens[s].rnd_mem)
            for (int i = 0; i < 4; i++)
               mem_vals[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
         else
            set_fixed_mem();
         run_dump(scens[s].pct, scens[s].tog, cyc);
         chk(cyc < 5000, $sformatf("scen%0d_timeout", s), $sformatf("%0d", cyc), "<5000");
         compare_dump($sformatf("scen%0d", s));
         if (s == 0) begin
            cyc_base = cyc;
            n_before = obs.size();
            pulse_halt();
            repeat (30) @(posedge clk);
            #2;
            chk(obs.size() == n_before && dump_done === 1'b1, "halt_after_done",
                $sformatf("recs=%0d done=%b", obs.size(), dump_done),
                $sformatf("recs=%0d done=1", n_before));
         end
         if (s == 1) cyc_tog = cyc;
      end
      chk(cyc_tog >= 2 * cyc_base - 3 && cyc_tog <= 2 * cyc_base + 3, "gated_latency",
          $sformatf("%0d", cyc_tog), $sformatf("~%0d", 2 * cyc_base));

      // Reset mid-dump, then a fresh halt restarts from the beginning
      do_reset();
      set_fixed_mem();
      obs.delete();
      ready_pct = 100; toggle = 0; drv_on = 1; mon_on = 1;
      pulse_halt();
      guard = 0;
      while (obs.size() < 2 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      chk(guard < 200, "mid_wait", $sformatf("%0d", guard), "<200");
      drv_on = 0;
      #1;
      rst = 1'b1; clk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk({busy, rec_valid, mem_rd_en, dump_done} === 4'b0000, "mid_rst_outputs",
          $sformatf("%b", {busy, rec_valid, mem_rd_en, dump_done}), "0000");
      rst = 1'b0;
      run_dump(100, 0, cyc);
      compare_dump("restart");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
